// File: rtl/stim_sequencer.sv
// Exhaustive 3-input stimulus sequencer: steps {a,b,c} through 000..111, holds each
// vector DWELL cycles and captures the downstream {x,y} response. Optional loop mode: STIM_LOOP_EN.
module stim_sequencer #(
  parameter int unsigned DWELL = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef STIM_LOOP_EN
  input  logic        loop,
`endif
  input  logic        x,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic [2:0]  vec_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] resp_vec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e      state_q;
  logic [2:0]  vec_q;
  logic [7:0]  dwell_q;
  logic [15:0] resp_q;
  logic [15:0] resp_d;
  logic        busy_q;
  logic        done_q;
  logic        dwell_last;
  logic        loop_en;

`ifdef STIM_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign dwell_last = (dwell_q == DWELL_LAST);

  // Response word with the current vector's {x,y} merged into its 2-bit slot.
  always_comb begin
    resp_d = resp_q;
    resp_d[{vec_q, 1'b0} +: 2] = {x, y};
  end

  always_ff @(posedge clk) begin
    // NOTE: resp_q is a plain flop word, so clearing it on reset is cheap and required
    // to guarantee an aborted sweep leaves no stale capture behind.
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      dwell_q <= 8'd0;
      resp_q  <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: every state register here uses <= so all updates see pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRIVE;
            busy_q  <= 1'b1;
            vec_q   <= 3'd0;
            dwell_q <= 8'd0;
            resp_q  <= 16'h0000;
          end
        end
        DRIVE: begin
          if (dwell_last) begin
            dwell_q <= 8'd0;
            if (vec_q != 3'd7) begin
              vec_q  <= vec_q + 3'd1;
              resp_q <= resp_d;
            end else if (loop_en) begin
              // Wrap for another pass: completion is flagged but the sweep keeps running.
              vec_q  <= 3'd0;
              resp_q <= 16'h0000;
              done_q <= 1'b1;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              resp_q  <= resp_d;
            end
          end else begin
            dwell_q <= dwell_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign {a, b, c} = vec_q;
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign resp_vec  = resp_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: DWELL=10 and DWELL=1 instances against a timeline model of
// a sweep, plus literal expectations for full-adder responses, reset abort and loop mode.
module tb_stim_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, loop, loop_eff;
  logic [1:0]  mode, rnd;
  logic        a10, b10, c10, x10, y10, busy10, done10;
  logic        a1, b1, c1, x1, y1, busy1, done1;
  logic [2:0]  vec10, vec1;
  logic [15:0] resp10, resp1;

  int n_vec = 0;
  int n_err = 0;

`ifdef STIM_LOOP_EN
  assign loop_eff = loop;
`else
  assign loop_eff = 1'b0;
`endif

  // Downstream block: 0 full adder, 1 tied 1/1, 2 tied 0/0, 3 random-ish.
  function automatic logic [1:0] downstream(logic [2:0] abc, logic [1:0] md, logic [1:0] r);
    case (md)
      2'd0:    return {^abc, (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0])};
      2'd1:    return 2'b11;
      2'd2:    return 2'b00;
      default: return r ^ {abc[0], 1'b0};
    endcase
  endfunction

  assign {x10, y10} = downstream({a10, b10, c10}, mode, rnd);
  assign {x1, y1}   = downstream({a1, b1, c1}, mode, rnd);

  stim_sequencer #(.DWELL(10)) u_dut10 (
    .clk(clk), .rst(rst), .start(start),
`ifdef STIM_LOOP_EN
    .loop(loop),
`endif
    .x(x10), .y(y10), .a(a10), .b(b10), .c(c10),
    .vec_idx(vec10), .busy(busy10), .done(done10), .resp_vec(resp10)
  );

  stim_sequencer #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
`ifdef STIM_LOOP_EN
    .loop(loop),
`endif
    .x(x1), .y(y1), .a(a1), .b(b1), .c(c1),
    .vec_idx(vec1), .busy(busy1), .done(done1), .resp_vec(resp1)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sweep model: elapsed cycles t within a sweep determine vector and sample points.
  bit          m_active [2];
  bit          m_done   [2];
  int          m_t      [2];
  int          m_vec    [2];
  logic [15:0] m_resp   [2];

  function automatic int dw(int i);
    return (i == 0) ? 10 : 1;
  endfunction

  task automatic model_step(int i, logic r, logic s, logic lp, logic [1:0] xy);
    bit was_done;
    int k;
    was_done  = m_done[i];
    m_done[i] = 1'b0;
    if (r) begin
      m_active[i] = 1'b0;
      m_t[i]      = 0;
      m_vec[i]    = 0;
      m_resp[i]   = 16'h0000;
    end else if (m_active[i]) begin
      k = m_t[i] / dw(i);
      if (m_t[i] % dw(i) == dw(i) - 1) begin
        m_resp[i][2*k +: 2] = xy;
        if (k == 7) begin
          m_done[i] = 1'b1;
          if (lp) begin
            m_resp[i] = 16'h0000;
            m_t[i]    = 0;
          end else begin
            m_active[i] = 1'b0;
          end
        end else begin
          m_t[i]++;
        end
      end else begin
        m_t[i]++;
      end
      if (m_active[i]) m_vec[i] = m_t[i] / dw(i);
    end else if (!was_done && s) begin
      m_active[i] = 1'b1;
      m_t[i]      = 0;
      m_vec[i]    = 0;
      m_resp[i]   = 16'h0000;
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge sees.
  bit chk_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("vec10",  32'(vec10),  32'(m_vec[0]));
        check("abc10",  32'({a10, b10, c10}), 32'(m_vec[0]));
        check("busy10", 32'(busy10), 32'(m_active[0]));
        check("done10", 32'(done10), 32'(m_done[0]));
        check("resp10", 32'(resp10), 32'(m_resp[0]));
        check("vec1",   32'(vec1),   32'(m_vec[1]));
        check("abc1",   32'({a1, b1, c1}), 32'(m_vec[1]));
        check("busy1",  32'(busy1),  32'(m_active[1]));
        check("done1",  32'(done1),  32'(m_done[1]));
        check("resp1",  32'(resp1),  32'(m_resp[1]));
      end
      model_step(0, rst, start, loop_eff, {x10, y10});
      model_step(1, rst, start, loop_eff, {x1, y1});
      chk_en = 1'b1;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      rnd = 2'($urandom);
    end
  endtask

  initial begin
    int busy_n10, busy_n1, done_n10, done_n1, first_done10, first_done1, abc_at25;
    int done_h, restart;
    int loop_done0, loop_done1, loop_done_n, busy_drop, vec_at80, stop_done_n, stop_idx;
    rst = 1'b1; start = 1'b0; loop = 1'b0; mode = 2'd0; rnd = 2'd0;
    tick(2);
    rst = 1'b0;
    check("reset_vec10",  32'(vec10), 32'd0);
    check("reset_busy10", 32'(busy10), 32'd0);
    check("reset_resp10", 32'(resp10), 32'h0);
    check("reset_resp1",  32'(resp1), 32'h0);

    // Full-adder sweep on both instances.
    busy_n10 = 0; busy_n1 = 0; done_n10 = 0; done_n1 = 0;
    first_done10 = -1; first_done1 = -1; abc_at25 = -1;
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy10) busy_n10++;
      if (busy1)  busy_n1++;
      if (done10) begin done_n10++; if (first_done10 < 0) first_done10 = i; end
      if (done1)  begin done_n1++;  if (first_done1 < 0)  first_done1  = i; end
      if (i == 25) abc_at25 = int'({a10, b10, c10});
      tick(1);
    end
    check("fa_busy_cycles10", 32'(busy_n10), 32'd80);
    check("fa_done_count10",  32'(done_n10), 32'd1);
    check("fa_done_at10",     32'(first_done10), 32'd80);
    check("fa_abc_at25",      32'(abc_at25), 32'd2);
    check("fa_resp10",        32'(resp10), 32'hD668);
    check("fa_busy_cycles1",  32'(busy_n1), 32'd8);
    check("fa_done_count1",   32'(done_n1), 32'd1);
    check("fa_done_at1",      32'(first_done1), 32'd8);
    check("fa_resp1",         32'(resp1), 32'hD668);

    // start held high: DONE then one IDLE cycle before the second sweep starts.
    done_h = 0; restart = -1;
    start = 1'b1; tick(1);
    for (int i = 0; i < 150; i++) begin
      if (done10) done_h++;
      if (done_h > 0 && busy10 && restart < 0) restart = i;
      tick(1);
    end
    start = 1'b0;
    check("held_done_count", 32'(done_h), 32'd1);
    check("held_restart_at", 32'(restart), 32'd82);
    tick(120);

    // Reset abort at cycle 35 of a sweep.
    start = 1'b1; tick(1); start = 1'b0;
    tick(34);
    check("abort_partial_resp", 32'(resp10), 32'h0028);
    tick(1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("abort_vec",  32'(vec10), 32'd0);
    check("abort_abc",  32'({a10, b10, c10}), 32'd0);
    check("abort_busy", 32'(busy10), 32'd0);
    check("abort_done", 32'(done10), 32'd0);
    check("abort_resp", 32'(resp10), 32'h0);
    done_h = 0;
    for (int i = 0; i < 100; i++) begin
      if (done10) done_h++;
      tick(1);
    end
    check("abort_no_done", 32'(done_h), 32'd0);

    // Tied responses: all ones, then all zeros with the clear visible right after start.
    mode = 2'd1;
    start = 1'b1; tick(1); start = 1'b0;
    tick(100);
    check("ones_resp10", 32'(resp10), 32'hFFFF);
    check("ones_resp1",  32'(resp1),  32'hFFFF);
    mode = 2'd2;
    start = 1'b1; tick(1); start = 1'b0;
    check("zeros_clear10", 32'(resp10), 32'h0);
    check("zeros_busy10",  32'(busy10), 32'd1);
    tick(100);
    check("zeros_resp10", 32'(resp10), 32'h0);
    check("zeros_resp1",  32'(resp1),  32'h0);

    // Random responses with sporadic start and reset, checked by the model every cycle.
    mode = 2'd3;
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    start = 1'b0; rst = 1'b0;
    tick(100);

`ifdef STIM_LOOP_EN
    rst = 1'b1; tick(1); rst = 1'b0;
    mode = 2'd0; loop = 1'b1;
    loop_done0 = -1; loop_done1 = -1; loop_done_n = 0; busy_drop = 0; vec_at80 = -1;
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 162; i++) begin
      if (done10) begin
        loop_done_n++;
        if (loop_done0 < 0) loop_done0 = i;
        else if (loop_done1 < 0) loop_done1 = i;
      end
      if (!busy10) busy_drop++;
      if (i == 80) vec_at80 = int'(vec10);
      tick(1);
    end
    check("loop_done_count", 32'(loop_done_n), 32'd2);
    check("loop_done_first", 32'(loop_done0), 32'd80);
    check("loop_done_second", 32'(loop_done1), 32'd160);
    check("loop_busy_drops", 32'(busy_drop), 32'd0);
    check("loop_wrap_vec", 32'(vec_at80), 32'd0);
    loop = 1'b0;
    stop_done_n = 0; stop_idx = -1;
    for (int i = 0; i < 100; i++) begin
      if (done10) begin stop_done_n++; if (stop_idx < 0) stop_idx = i; end
      tick(1);
    end
    check("loop_stop_done_count", 32'(stop_done_n), 32'd1);
    check("loop_stop_done_at", 32'(stop_idx), 32'd78);
    check("loop_stop_busy", 32'(busy10), 32'd0);
    check("loop_stop_resp", 32'(resp10), 32'hD668);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 The module SHALL have parameter DWELL, default 10, giving the number of clock cycles each input vector is held (legal range 1..255).
REQ-002 The module SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The module SHALL have port rst  input  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-004 The module SHALL have port start  input  1  level-sampled request to run one sweep, honoured only in IDLE.
REQ-005 The module SHALL have ports a, b, c  output  1 each  drive the downstream combinational block's inputs, {a,b,c} = vec_idx with a as MSB.
REQ-006 The module SHALL have ports x, y  input  1 each  responses of the downstream combinational block.
REQ-007 The module SHALL have port vec_idx  output  3  index of the vector currently driven.
REQ-008 The module SHALL have port busy  output  1  high while in DRIVE.
REQ-009 The module SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-010 The module SHALL have port resp_vec  output  16  captured responses, resp_vec[2k+1:2k] = {x,y} sampled for vector k.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, DRIVE and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the FSM SHALL enter DRIVE with vec_idx=0, dwell counter=0 and resp_vec cleared to 0 on that same edge.
REQ-013 In DRIVE, the FSM SHALL hold the vector for exactly DWELL cycles, counting the dwell counter 0..DWELL-1.
REQ-014 On the edge ending the cycle where the dwell counter = DWELL-1, the FSM SHALL write {x,y} into resp_vec[2*vec_idx+1 : 2*vec_idx].
REQ-015 On that same edge, the FSM SHALL increment vec_idx and clear the dwell counter if vec_idx<7, else enter DONE.
REQ-016 In DWELL=1 operation, each vector SHALL be driven and sampled in a single cycle.
REQ-017 Sweep latency SHALL be busy high for exactly 8*DWELL cycles, then done=1 for exactly one cycle (DONE state), then IDLE.
REQ-018 start SHALL be ignored while in DRIVE or DONE, and no restart SHALL be queued.
REQ-019 In IDLE and DONE, {a,b,c} SHALL hold the last driven value and vec_idx SHALL hold its last value.
REQ-020 resp_vec SHALL hold its value until the next accepted start or reset.
REQ-021 vec_idx SHALL NOT wrap in single-pass mode; the 7->0 transition occurs only via start or loop mode.
REQ-022 The dwell counter SHALL be 8 bits wide, and comparison against DWELL-1 SHALL be unsigned.

Reset
REQ-023 When rst=1 at a rising edge, the FSM SHALL enter IDLE and set vec_idx=0, a=b=c=0, busy=0, done=0, resp_vec=16'h0000 and the dwell counter to 0.
REQ-024 rst SHALL take priority over start and over any in-progress sweep.
REQ-025 An aborted sweep (rst mid-DRIVE) SHALL leave no captured data and produce no done pulse.
REQ-026 The first start SHALL be accepted on the edge after rst deasserts.

Configuration
REQ-027 When STIM_LOOP_EN is defined, the module SHALL add input port loop (1 bit).
REQ-028 With STIM_LOOP_EN defined and loop=1 at the final sample edge of vector 7, the FSM SHALL pulse done for one cycle while remaining in DRIVE.
REQ-029 In that loop case, vec_idx SHALL wrap to 0, resp_vec SHALL be cleared to 0 on the wrap edge and then refilled, and busy SHALL stay high.
REQ-030 With STIM_LOOP_EN defined and loop=0, behaviour SHALL be identical to single-pass operation.
REQ-031 When STIM_LOOP_EN is undefined, the loop port SHALL be absent and only single-pass behaviour SHALL exist.

Verification
REQ-032 The bench SHALL cover: DWELL=10, downstream modelled as full adder (x=a^b^c, y=maj(a,b,c)), start pulse -> busy high 80 cycles, {a,b,c} steps 000..111 every 10 cycles, done pulses once, resp_vec=16'hD668.
REQ-033 The bench SHALL cover: DWELL=1, same model -> busy 8 cycles, resp_vec=16'hD668, done one cycle after the last vector.
REQ-034 The bench SHALL cover: start held high throughout a DWELL=10 sweep -> exactly one sweep runs, second sweep begins on the first edge after DONE.
REQ-035 The bench SHALL cover: rst asserted at cycle 35 of a DWELL=10 sweep -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-036 The bench SHALL cover: x,y tied 1,1 -> resp_vec=16'hFFFF; then a new start with x,y tied 0,0 -> resp_vec reads 0 immediately after start, ends 16'h0000.
REQ-037 The bench SHALL cover, with STIM_LOOP_EN defined and loop=1 for two passes: done pulses at cycles 80 and 160, busy never drops, vec_idx wraps 7->0; loop=0 -> stops after the current pass.
